// File: rtl/lpf_pkg.sv
// lpf_pkg: shared encodings, constants and width helper for the streaming 3x3 low-pass filter
package lpf_pkg;
  typedef enum logic [1:0] {MODE_BYPASS = 2'b00, MODE_BOX = 2'b01, MODE_GAUSS = 2'b10, MODE_BOX_ALT = 2'b11} mode_e;
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_e;
  localparam int DIV9_MUL = 57;
  localparam int DIV9_SHIFT = 9;
  function automatic int sum_w(input int pix_w);
    return pix_w + 4;
  endfunction
endpackage

// File: rtl/lpf_line_buf.sv
// lpf_line_buf: one image line of pixels, asynchronous read returns the old word on a same-address write
module lpf_line_buf #(
  parameter int DW = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem [DEPTH];
  assign rdata = mem[raddr];
  always_ff @(posedge clock) if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/lpf_stream_3x3.sv
// lpf_stream_3x3: one-pixel-per-clock 3x3 bypass/box/Gaussian filter with two line buffers.
// Define LPF_GAUSS_EN to compile in the Gaussian datapath; otherwise mode 10 falls back to box.
module lpf_stream_3x3 import lpf_pkg::*; #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             frame_done,
  output logic             frame_err
);
  localparam int SW = sum_w(PIX_W);
  localparam int PW = PIX_W + 10;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  state_e state, state_n;
  mode_e mode_q;
  logic rdy_en, stall, acc, take, restart, produce, shift, m_last, border;
  logic [CW-1:0] ci, oc, col;
  logic [RW-1:0] ri, orow;
  logic [PIX_W-1:0] top_new, mid_new, box_pix, filt;
  logic [PIX_W:0] box_q;
  logic [SW-1:0] box_sum;
  logic [2:0][1:0][PIX_W-1:0] w;
  logic [2:0][2:0][PIX_W-1:0] p;
  lpf_line_buf #(.DW(PIX_W), .DEPTH(IMG_W)) lb_a (
    .clock(clock), .we(take), .waddr(col), .wdata(s_data), .raddr(col), .rdata(mid_new)
  );
  lpf_line_buf #(.DW(PIX_W), .DEPTH(IMG_W)) lb_b (
    .clock(clock), .we(take), .waddr(col), .wdata(mid_new), .raddr(col), .rdata(top_new)
  );
  always_comb begin
    stall = m_valid && !m_ready;
    s_ready = rdy_en && !stall && state != FLUSH;
    acc = s_valid && s_ready;
    take = acc && (state != IDLE || s_sof);
    restart = take && s_sof;
    produce = (state == RUN && acc && !s_sof) || (state == FLUSH && !stall);
    shift = take || (state == FLUSH && !stall);
    col = restart ? '0 : ci;
    frame_done = m_valid && m_ready && m_last;
    state_n = restart ? FILL
      : (state == FILL && acc && ri == RW'(1) && ci == '0) ? RUN
      : (state == RUN && acc && ri == R_LAST && ci == C_LAST) ? FLUSH
      : (state == FLUSH && produce && orow == R_LAST && oc == C_LAST) ? IDLE
      : state;
  end
  always_ff @(posedge clock) state <= !reset ? IDLE : state_n;
  // p[row][col]: column 2 is the one arriving this cycle, column 1 is the output's centre column
  assign p = {{s_data, w[2][1], w[2][0]}, {mid_new, w[1][1], w[1][0]}, {top_new, w[0][1], w[0][0]}};
  assign border = orow == '0 || orow == R_LAST || oc == '0 || oc == C_LAST;
  always_comb begin
    box_sum = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        box_sum = box_sum + SW'(p[i][j]);
    box_q = (PIX_W + 1)'((PW'(box_sum) * PW'(DIV9_MUL)) >> DIV9_SHIFT);
    box_pix = box_q[PIX_W] ? '1 : box_q[PIX_W-1:0];
  end
`ifdef LPF_GAUSS_EN
  logic [SW-1:0] gau_sum;
  always_comb
    gau_sum = SW'(p[0][0]) + SW'(p[0][2]) + SW'(p[2][0]) + SW'(p[2][2])
      + ((SW'(p[0][1]) + SW'(p[1][0]) + SW'(p[1][2]) + SW'(p[2][1])) << 1)
      + (SW'(p[1][1]) << 2);
  assign filt = (border || mode_q == MODE_BYPASS) ? p[1][1]
    : (mode_q == MODE_GAUSS) ? PIX_W'(gau_sum >> 4) : box_pix;
`else
  assign filt = (border || mode_q == MODE_BYPASS) ? p[1][1] : box_pix;
`endif
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdy_en <= 1'b0;
      mode_q <= MODE_BYPASS;
      ci <= '0;
      ri <= '0;
      oc <= '0;
      orow <= '0;
      w <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_sof <= 1'b0;
      m_eol <= 1'b0;
      m_last <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (restart) mode_q <= mode_e'(mode);
      if (restart && state != IDLE) frame_err <= 1'b1;
      if (shift) begin
        w <= {{s_data, w[2][1]}, {mid_new, w[1][1]}, {top_new, w[0][1]}};
        ci <= col == C_LAST ? '0 : col + 1'b1;
        ri <= restart ? '0 : (col != C_LAST) ? ri : (ri == R_LAST) ? '0 : ri + 1'b1;
      end
      if (restart) begin
        oc <= '0;
        orow <= '0;
      end else if (produce) begin
        oc <= oc == C_LAST ? '0 : oc + 1'b1;
        orow <= (oc != C_LAST) ? orow : (orow == R_LAST) ? '0 : orow + 1'b1;
      end
      if (!stall) begin
        m_valid <= produce;
        if (produce) begin
          m_data <= filt;
          m_sof <= oc == '0 && orow == '0;
          m_eol <= oc == C_LAST;
          m_last <= oc == C_LAST && orow == R_LAST;
        end
      end
    end
  end
endmodule
